// File: rtl/fp_sub_correct_if.sv
// fp_sub_correct_if: digit stream, flag capture and ROM bus around the correction stage
interface fp_sub_correct_if #(
  parameter int RADIX  = 32,
  parameter int DIGITS = 14
);
  localparam int AW = $clog2(DIGITS);
  logic             start;
  logic             digit_in_valid;
  logic [RADIX-1:0] digit_in;
  logic             sub_done;
  logic             sub_flag;
  logic             sub_carry;
  logic [AW-1:0]    const_addr;
  logic [RADIX-1:0] const_digit;
  logic             digit_out_valid;
  logic [RADIX-1:0] digit_out;
  logic             carry_out;
  logic             flag_out;
  logic             sub_carry_out;
  logic             err;
  logic             done;
  modport slave (
    input  start, digit_in_valid, digit_in, sub_done, sub_flag, sub_carry, const_digit,
    output const_addr, digit_out_valid, digit_out, carry_out, flag_out, sub_carry_out, err, done
  );
  modport master (
    output start, digit_in_valid, digit_in, sub_done, sub_flag, sub_carry, const_digit,
    input  const_addr, digit_out_valid, digit_out, carry_out, flag_out, sub_carry_out, err, done
  );
endinterface

// File: rtl/fp_sub_correct.sv
// fp_sub_correct: buffers a digit-serial difference and re-streams it minus the modulus when flagged
module fp_sub_correct #(
  parameter int RADIX  = 32,
  parameter int DIGITS = 14
) (
  input logic              clk,
  input logic              rst,
  fp_sub_correct_if.slave  bus
);
  localparam int CW = $clog2(DIGITS + 1);
  localparam int AW = $clog2(DIGITS);
  typedef enum logic [2:0] {IDLE, LOAD, PRE, EMIT, FIN} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    wr_cnt_q, rd_cnt_q;
  logic [RADIX-1:0] mem_q [DIGITS];
  logic             borrow_q, flag_q, carry_q, flag_seen_q;
  logic [AW-1:0]    const_addr_q;
  logic [RADIX-1:0] digit_out_q;
  logic             digit_out_valid_q, carry_out_q, flag_out_q, sub_carry_out_q, err_q, done_q;
  logic [RADIX:0]   diff;
  logic             go, wr, cap, last;
  // Decode events, next state and the borrow-propagating digit subtraction
  always_comb begin
    go      = state_q == IDLE && bus.start;
    wr      = state_q == LOAD && bus.digit_in_valid && wr_cnt_q < CW'(DIGITS);
    cap     = (state_q == LOAD || state_q == PRE) && bus.sub_done && !flag_seen_q;
    last    = rd_cnt_q == CW'(DIGITS - 1);
    diff    = {1'b0, mem_q[AW'(rd_cnt_q)]} - {1'b0, bus.const_digit & {RADIX{flag_q}}}
              - {{RADIX{1'b0}}, borrow_q};
    state_d = go ? LOAD :
              (state_q == LOAD && wr_cnt_q == CW'(DIGITS) && flag_seen_q) ? PRE :
              state_q == PRE ? EMIT :
              (state_q == EMIT && last) ? FIN :
              state_q == FIN ? IDLE : state_q;
  end
  // Digit buffer; contents are always rewritten before being read, so no reset
  always_ff @(posedge clk) begin
    if (wr) mem_q[AW'(wr_cnt_q)] <= bus.digit_in;
  end
  // Control, capture and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= IDLE;
      wr_cnt_q          <= '0;
      rd_cnt_q          <= '0;
      borrow_q          <= 1'b0;
      flag_q            <= 1'b0;
      carry_q           <= 1'b0;
      flag_seen_q       <= 1'b0;
      const_addr_q      <= '0;
      digit_out_q       <= '0;
      digit_out_valid_q <= 1'b0;
      carry_out_q       <= 1'b0;
      flag_out_q        <= 1'b0;
      sub_carry_out_q   <= 1'b0;
      err_q             <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      digit_out_valid_q <= state_q == EMIT;
      done_q            <= state_q == FIN;
      if (go) begin
        wr_cnt_q        <= '0;
        rd_cnt_q        <= '0;
        borrow_q        <= 1'b0;
        flag_q          <= 1'b0;
        carry_q         <= 1'b0;
        flag_seen_q     <= 1'b0;
        err_q           <= 1'b0;
        carry_out_q     <= 1'b0;
        flag_out_q      <= 1'b0;
        sub_carry_out_q <= 1'b0;
      end
      if (wr) wr_cnt_q <= wr_cnt_q + 1'b1;
      if (state_q == LOAD && bus.digit_in_valid && !wr) err_q <= 1'b1;
      if (cap) begin
        flag_q      <= bus.sub_flag;
        carry_q     <= bus.sub_carry;
        flag_seen_q <= 1'b1;
      end
      if (state_q == PRE) const_addr_q <= '0;
      if (state_q == EMIT) begin
        if (!last) const_addr_q <= AW'(rd_cnt_q + 1'b1);
        digit_out_q <= diff[RADIX-1:0];
        borrow_q    <= diff[RADIX];
        rd_cnt_q    <= rd_cnt_q + 1'b1;
      end
      if (state_q == FIN) begin
        carry_out_q     <= borrow_q;
        flag_out_q      <= flag_q;
        sub_carry_out_q <= carry_q;
      end
    end
  end
  assign bus.const_addr      = const_addr_q;
  assign bus.digit_out_valid = digit_out_valid_q;
  assign bus.digit_out       = digit_out_q;
  assign bus.carry_out       = carry_out_q;
  assign bus.flag_out        = flag_out_q;
  assign bus.sub_carry_out   = sub_carry_out_q;
  assign bus.err             = err_q;
  assign bus.done            = done_q;
endmodule

// File: tb/tb_fp_sub_correct.sv
// tb_fp_sub_correct: random and directed transactions checked against a wide-integer model
module tb_fp_sub_correct;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int run_len = 0;
  bit prev_v = 1'b0;
  bit prev_d = 1'b0;
  logic [15:0] rom [4];
  logic [15:0] exp_dig [$];
  logic exp_carry, exp_flag, exp_scar, exp_err;
  fp_sub_correct_if #(.RADIX(16), .DIGITS(4)) bus ();
  fp_sub_correct #(.RADIX(16), .DIGITS(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.const_digit = rom[bus.const_addr];
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] c, input bit fl);
    return fl ? {1'b0, a} - {1'b0, c} : {1'b0, a};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_zero(input string nm);
    chk({nm, "_valid"}, bus.digit_out_valid, 0);
    chk({nm, "_digit"}, bus.digit_out, 0);
    chk({nm, "_addr"}, bus.const_addr, 0);
    chk({nm, "_carry"}, bus.carry_out, 0);
    chk({nm, "_flag"}, bus.flag_out, 0);
    chk({nm, "_scar"}, bus.sub_carry_out, 0);
    chk({nm, "_err"}, bus.err, 0);
    chk({nm, "_done"}, bus.done, 0);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      run_len = 0;
      prev_v = 1'b0;
      prev_d = 1'b0;
    end else begin
      if (prev_v && !bus.digit_out_valid) chk("done_after_last", bus.done, 1);
      if (prev_d) chk("done_width", bus.done, 0);
      if (bus.digit_out_valid) begin
        if (exp_dig.size() == 0) chk("unexpected_digit", bus.digit_out_valid, 0);
        else chk("digit", bus.digit_out, exp_dig.pop_front());
        run_len++;
      end
      if (bus.done) begin
        chk("run_len", run_len, 4);
        chk("carry_out", bus.carry_out, exp_carry);
        chk("flag_out", bus.flag_out, exp_flag);
        chk("sub_carry_out", bus.sub_carry_out, exp_scar);
        chk("err", bus.err, exp_err);
        run_len = 0;
        done_cnt++;
      end
      prev_v = bus.digit_out_valid;
      prev_d = bus.done;
    end
  end
  task automatic txn(input logic [63:0] a, input logic [63:0] c, input bit fl, input bit sc,
                     input int gap, input int dpos, input bit extra, input bit restart, input bit abort);
    logic [64:0] r;
    int n, d0;
    for (int i = 0; i < 4; i++) rom[i] = c[16*i +: 16];
    r = model(a, c, fl);
    for (int i = 0; i < 4; i++) exp_dig.push_back(r[16*i +: 16]);
    exp_carry = r[64];
    exp_flag = fl;
    exp_scar = sc;
    exp_err = extra;
    bus.digit_in_valid = 1'b1;
    bus.digit_in = 16'($urandom);
    tick;
    bus.digit_in_valid = 1'b0;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    if (dpos < 0) begin
      bus.sub_done = 1'b1;
      bus.sub_flag = fl;
      bus.sub_carry = sc;
      tick;
      bus.sub_done = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      repeat (gap) tick;
      bus.digit_in_valid = 1'b1;
      bus.digit_in = a[16*i +: 16];
      if (dpos == i) begin
        bus.sub_done = 1'b1;
        bus.sub_flag = fl;
        bus.sub_carry = sc;
      end
      if (i == 3 && dpos < 3) begin
        bus.sub_done = 1'b1;
        bus.sub_flag = !fl;
        bus.sub_carry = !sc;
      end
      if (restart && i == 1) bus.start = 1'b1;
      tick;
      bus.digit_in_valid = 1'b0;
      bus.sub_done = 1'b0;
      bus.start = 1'b0;
      bus.sub_flag = 1'($urandom);
      bus.sub_carry = 1'($urandom);
    end
    if (extra) begin
      bus.digit_in_valid = 1'b1;
      bus.digit_in = 16'($urandom);
      tick;
      bus.digit_in_valid = 1'b0;
    end
    if (dpos >= 4) begin
      bus.sub_done = 1'b1;
      bus.sub_flag = fl;
      bus.sub_carry = sc;
      tick;
      bus.sub_done = 1'b0;
    end
    n = 0;
    while (!bus.digit_out_valid && n < 20) begin
      tick;
      n++;
    end
    chk("latency", n, 3);
    if (abort) begin
      tick;
      rst = 1'b0;
      #1;
      check_zero("abort");
      exp_dig.delete();
      d0 = done_cnt;
      repeat (3) tick;
      rst = 1'b1;
      repeat (10) tick;
      chk("no_done_after_abort", done_cnt, d0);
      return;
    end
    n = 0;
    while (!bus.done && n < 20) begin
      tick;
      n++;
    end
    chk("done_seen", bus.done, 1);
    tick;
    chk("carry_hold", bus.carry_out, exp_carry);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [64:0] m;
    int dpos;
    bus.start = 1'b0;
    bus.digit_in_valid = 1'b0;
    bus.digit_in = '0;
    bus.sub_done = 1'b0;
    bus.sub_flag = 1'b0;
    bus.sub_carry = 1'b0;
    for (int i = 0; i < 4; i++) rom[i] = '0;
    repeat (3) tick;
    check_zero("reset");
    rst = 1'b1;
    tick;
    m = model(64'h0004_0003_0002_0001, 64'h5, 1'b0);
    chk("model_pass", m, 65'h0_0004_0003_0002_0001);
    m = model(64'h0000_0000_0001_0003, 64'h5, 1'b1);
    chk("model_sub", m, 65'h0_0000_0000_0000_FFFE);
    m = model(64'h0, 64'h1, 1'b1);
    chk("model_borrow", m, 65'h1_FFFF_FFFF_FFFF_FFFF);
    txn(64'h0004_0003_0002_0001, 64'h5, 0, 0, 0, 4, 0, 0, 0);
    txn(64'h0000_0000_0001_0003, 64'h5, 1, 0, 0, 3, 0, 0, 0);
    txn(64'h0000_0000_0001_0003, 64'h5, 1, 1, 2, -1, 0, 0, 0);
    txn(64'h0000_0000_0001_0003, 64'h5, 1, 0, 0, 4, 1, 0, 0);
    txn(64'h0004_0003_0002_0001, 64'h5, 0, 0, 0, 3, 0, 0, 1);
    txn(64'h0004_0003_0002_0001, 64'h5, 0, 0, 0, 4, 0, 0, 0);
    txn(64'h0000_0000_0001_0003, 64'h5, 1, 0, 1, 2, 0, 1, 0);
    for (int t = 0; t < 30; t++) begin
      dpos = int'($urandom_range(0, 5)) - 1;
      txn({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
          int'($urandom_range(0, 2)), dpos, dpos == 4 && $urandom_range(0, 2) == 0,
          $urandom_range(0, 4) == 0, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
